// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared definitions for the 4-channel round-robin arbiter:
//                FSM state encoding, hold-counter width and the round-robin
//                winner search.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Hold counter width; wide enough for MAX_HOLD up to 31.
    localparam int C_CNT_W = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Returns the first requesting channel in the order ptr+1 .. ptr+4
    // (mod 4). ptr+4 is ptr itself, so the previous owner is considered
    // last. The result is only meaningful when req is non-zero.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                           input logic [3:0] req);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_4X2.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_4X2
//  Description : One-hot (or zero) to binary index encoder.
//  Ports       : i_onehot [3:0] one-hot vector
//                o_idx    [1:0] binary index of the set bit (00 when zero)
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_4X2 (
    input  logic [3:0] i_onehot,
    output logic [1:0] o_idx
);

    // OR-based encoding: valid for one-hot or all-zero inputs.
    assign o_idx = {i_onehot[3] | i_onehot[2], i_onehot[3] | i_onehot[1]};

endmodule
`default_nettype wire

// File: rtl/rr_arb_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_4
//  Description : Four-channel round-robin arbiter with a bounded hold time.
//                An owner keeps the grant until it pulses done, drops its
//                request, or holds for MAX_HOLD cycles (forced release with
//                a timeout pulse). Every release passes through one IDLE
//                cycle before the next grant.
//  Ports       : clk         in   clock, rising edge
//                rst         in   synchronous active-high reset
//                req   [3:0] in   level-sensitive channel requests
//                done        in   release pulse from current owner
//                grant [3:0] out  registered one-hot grant
//                grant_valid out  grant is non-zero
//                grant_idx[1:0] out binary owner index, 00 when idle
//                timeout     out  one-cycle forced-release pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic [1:0] grant_idx,
    output logic       timeout
);

    state_t               r_state_q,   w_state_d;
    logic [3:0]           r_grant_q,   w_grant_d;
    logic                 r_timeout_q, w_timeout_d;
    logic [C_CNT_W-1:0]   r_cnt_q,     w_cnt_d;
    logic [1:0]           r_ptr_q,     w_ptr_d;

    logic [1:0]           w_enc_idx;
    logic [1:0]           w_pick;
    logic                 w_owner_req;
    logic                 w_hold_hit;

    encoder_4X2 u_enc (
        .i_onehot (r_grant_q),
        .o_idx    (w_enc_idx)
    );

    assign w_pick      = rr_pick(r_ptr_q, req);
    assign w_owner_req = req[w_enc_idx];
    // Counter reads 0 in the first grant cycle, so MAX_HOLD-1 marks the
    // last permitted cycle of ownership.
    assign w_hold_hit  = (r_cnt_q == C_CNT_W'(MAX_HOLD - 1));

    always_comb begin
        w_state_d   = r_state_q;
        w_grant_d   = r_grant_q;
        w_timeout_d = 1'b0;
        w_cnt_d     = r_cnt_q;
        w_ptr_d     = r_ptr_q;
        case (r_state_q)
            ST_IDLE: begin
                if (|req) begin
                    w_state_d = ST_GRANT;
                    w_grant_d = 4'b0001 << w_pick;
                    w_ptr_d   = w_pick;
                    w_cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (done || !w_owner_req || w_hold_hit) begin
                    w_state_d   = ST_IDLE;
                    w_grant_d   = 4'b0000;
                    w_cnt_d     = '0;
                    // Timeout only when the counter alone forced the release.
                    w_timeout_d = w_hold_hit && !done && w_owner_req;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_grant_d = 4'b0000;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_grant_q   <= 4'b0000;
            r_timeout_q <= 1'b0;
            r_cnt_q     <= '0;
            r_ptr_q     <= 2'b11;   // channel 0 searched first after reset
        end else begin
            r_state_q   <= w_state_d;
            r_grant_q   <= w_grant_d;
            r_timeout_q <= w_timeout_d;
            r_cnt_q     <= w_cnt_d;
            r_ptr_q     <= w_ptr_d;
        end
    end

    assign grant       = r_grant_q;
    assign grant_valid = |r_grant_q;
    assign grant_idx   = grant_valid ? w_enc_idx : 2'b00;
    assign timeout     = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb_4
//  Description : Self-checking bench for rr_arb_4 (MAX_HOLD = 4): directed
//                scenarios followed by randomized traffic, all compared
//                against a behavioural ownership model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_4;

    localparam int C_MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       timeout;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model: which channel owns the bus, who owned it last,
    // and for how many visible cycles the current owner has held it.
    int m_owner = -1;
    int m_last  = 3;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arb_4 #(.MAX_HOLD(C_MH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [3:0] q, input bit d);
        bit found;
        int c;
        if (r) begin
            m_owner = -1; m_last = 3; m_held = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (!found && q[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                end
            end
            if (found) begin
                m_last = m_owner;
                m_held = 1;
            end
        end else begin
            if (d || !q[m_owner] || m_held == C_MH) begin
                m_to    = (m_held == C_MH) && !d && q[m_owner];
                m_owner = -1;
            end else begin
                m_to = 1'b0;
                m_held++;
            end
        end
    endtask

    // Drive inputs on the falling edge, update the model at the rising
    // edge, and compare shortly after it.
    task automatic cycle(input bit r, input logic [3:0] q, input bit d);
        logic [3:0] eg;
        @(negedge clk);
        rst = r; req = q; done = d;
        @(posedge clk);
        model_step(r, q, d);
        #1;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("grant",       32'(grant),       32'(eg));
        chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        chk("grant_idx",   32'(grant_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("timeout",     32'(timeout),     32'(m_to));
    endtask

    logic [3:0] rot_seq [9];
    logic [3:0] to_grant[6];
    logic       to_pulse[6];

    initial begin
        rot_seq  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001};
        to_grant = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010};
        to_pulse = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rst = 1'b1; req = 4'b0000; done = 1'b0;

        // Reset with all channels requesting.
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);
        chk("rst_grant",   32'(grant),     32'h0);
        chk("rst_idx",     32'(grant_idx), 32'h0);
        chk("rst_timeout", 32'(timeout),   32'h0);

        // Rotation: done held high, ignored while idle.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 4'b1111, 1'b1);
            chk("rotation", 32'(grant), 32'(rot_seq[i]));
        end

        // Move the pointer to channel 2, then request 0 and 1 only.
        cycle(1'b0, 4'b1111, 1'b1);
        cycle(1'b0, 4'b0100, 1'b0);
        chk("to_ch2", 32'(grant), 32'h4);
        cycle(1'b0, 4'b0100, 1'b1);
        cycle(1'b0, 4'b0011, 1'b0);
        chk("wrap_grant", 32'(grant),       32'h1);
        chk("wrap_idx",   32'(grant_idx),   32'h0);
        chk("wrap_valid", 32'(grant_valid), 32'h1);

        // Owner drops its request.
        cycle(1'b0, 4'b0000, 1'b0);
        chk("drop_release", 32'(grant), 32'h0);
        cycle(1'b0, 4'b0000, 1'b0);

        // Forced release after MAX_HOLD cycles.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 4'b0010, 1'b0);
            chk("hold_grant", 32'(grant),   32'(to_grant[i]));
            chk("hold_tmo",   32'(timeout), 32'(to_pulse[i]));
        end

        // done in the last permitted cycle suppresses the timeout.
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0010, 1'b1);
        chk("done_prec_grant", 32'(grant),   32'h0);
        chk("done_prec_tmo",   32'(timeout), 32'h0);

        // Reset in the middle of a grant.
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        chk("mid_pre", 32'(grant), 32'h2);
        cycle(1'b1, 4'b0010, 1'b0);
        chk("mid_rst", 32'(grant), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  4'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles one grant may be held before a forced release (legal range 2..31).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  4  per-channel request, level-sensitive, bit i = channel i.
REQ-005 SHALL have port done  input  1  single-cycle release pulse from the current owner.
REQ-006 SHALL have port grant  output  4  registered one-hot grant, 4'b0000 when no owner.
REQ-007 SHALL have port grant_valid  output  1  high while grant is non-zero.
REQ-008 SHALL have port grant_idx  output  2  binary index of the granted channel, 2'b00 when grant_valid is low.
REQ-009 SHALL have port timeout  output  1  single-cycle pulse marking a forced release.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-011 SHALL, in IDLE with req != 0 at a rising edge, enter GRANT and drive grant one-hot at that edge (1-cycle latency from sampled req).
REQ-012 SHALL stay in IDLE with grant = 4'b0000 while req == 0.
REQ-013 SHALL select the owner round-robin: search order ptr+1, ptr+2, ptr+3, ptr+4 (mod 4); first requesting channel wins.
REQ-014 SHALL update the 2-bit pointer ptr to the winning index on every grant.
REQ-015 SHALL guarantee grant is never multi-hot and never changes owner without first passing through IDLE.
REQ-016 SHALL, in GRANT, release (return to IDLE, grant = 0 at the next edge) when any of these holds at an edge: done = 1; req[owner] = 0; hold counter == MAX_HOLD-1.
REQ-017 SHALL spend exactly one cycle in IDLE after any release; earliest re-grant is the second edge after the release condition is sampled.
REQ-018 SHALL run a 5-bit hold counter: cleared on entering GRANT, incremented each GRANT cycle, saturating is not needed (release bounds it).
REQ-019 SHALL assert timeout for one cycle, coincident with grant returning to 0, only when release is due solely to the counter; done or req drop in the same cycle takes precedence and suppresses timeout.
REQ-020 SHALL ignore done while in IDLE.
REQ-021 SHALL allow the released owner to win again only if no other channel requests (round-robin fairness).
REQ-022 SHALL derive grant_idx combinationally from the registered grant, forced to 2'b00 when grant_valid = 0 (never X).

Reset
REQ-023 SHALL, with rst high at a rising edge, force state IDLE, grant 4'b0000, grant_valid 0, grant_idx 2'b00, timeout 0, hold counter 0, ptr 2'b11 (channel 0 has first priority after reset).
REQ-024 SHALL give rst priority over every other input, including mid-grant; no grant is visible on the edge where rst is sampled high.

Structure
REQ-025 SHALL place the FSM state encoding (IDLE, GRANT) and the counter width constant in a shared package, arb_pkg.
REQ-026 SHALL instantiate encoder_4X2 as the single sub-module converting grant to grant_idx, with its output gated by grant_valid.

Verification
REQ-027 SHALL cover reset: rst high 2 cycles with req = 4'b1111 -> grant 0000, grant_idx 00, timeout 0; first edge after rst low -> grant 0001.
REQ-028 SHALL cover rotation: req held 4'b1111, done pulsed each GRANT cycle -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-029 SHALL cover skip/wrap: ptr = 2 (last grant 0100), req = 4'b0011 -> next grant 0001, grant_idx 00, grant_valid 1.
REQ-030 SHALL cover timeout: MAX_HOLD = 4, req = 4'b0010 held, no done -> grant 0010 for exactly 4 cycles, then grant 0000 with timeout = 1 for one cycle, then re-grant 0010.
REQ-031 SHALL cover precedence: done = 1 in the same cycle the counter hits MAX_HOLD-1 -> release with timeout = 0; owner dropping req -> release next edge; rst asserted mid-GRANT -> grant 0000 at that edge.
